// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit direction counters; registered 1-cycle prediction over a valid/allowin handshake.
// Define BP_UPDATE_BYPASS_EN to let a same-edge, same-index update feed the lookup.
module branch_predictor #(
  parameter int ENTRIES = 64,
  parameter int IDX_W   = $clog2(ENTRIES),
  parameter int TAG_W   = 30 - IDX_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        req_valid,
  input  logic [31:0] req_pc,
  output logic        req_allowin,
  output logic        resp_valid,
  input  logic        resp_allowin,
  output logic [31:0] resp_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target
);

  logic [ENTRIES-1:0] v_q;
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [31:0]        tgt_q [ENTRIES];
  logic [1:0]         ctr_q [ENTRIES];

  logic [IDX_W-1:0] u_idx;
  logic [TAG_W-1:0] u_tag;
  logic             u_hit;
  logic             u_wr;
  logic [1:0]       u_ctr;
  logic [31:0]      u_tgt;
  logic             unused_bits;

  assign u_idx       = upd_pc[2 +: IDX_W];
  assign u_tag       = upd_pc[2+IDX_W +: TAG_W];
  assign u_hit       = v_q[u_idx] && (tag_q[u_idx] == u_tag);
  assign unused_bits = ^upd_pc[1:0];

  // Post-update image of the indexed entry; u_wr says whether it gets written.
  always_comb begin
    u_wr  = 1'b0;
    u_ctr = ctr_q[u_idx];
    u_tgt = tgt_q[u_idx];
    if (upd_valid) begin
      if (u_hit) begin
        u_wr = 1'b1;
        if (upd_taken) begin
          u_ctr = (ctr_q[u_idx] == 2'd3) ? 2'd3 : ctr_q[u_idx] + 2'd1;
          u_tgt = upd_target;
        end else begin
          u_ctr = (ctr_q[u_idx] == 2'd0) ? 2'd0 : ctr_q[u_idx] - 2'd1;
        end
      end else if (upd_taken) begin
        u_wr  = 1'b1;
        u_ctr = 2'd2;
        u_tgt = upd_target;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_q <= '0;
    end else if (u_wr) begin
      v_q[u_idx] <= 1'b1;
    end
  end

  // Payload storage carries no reset; the valid bits alone gate its use.
  always_ff @(posedge clk) begin
    if (u_wr) begin
      tag_q[u_idx] <= u_tag;
      tgt_q[u_idx] <= u_tgt;
      ctr_q[u_idx] <= u_ctr;
    end
  end

  logic [IDX_W-1:0] r_idx;
  logic [TAG_W-1:0] r_tag;
  logic             l_v;
  logic [TAG_W-1:0] l_tag;
  logic [31:0]      l_tgt;
  logic [1:0]       l_ctr;
  logic             l_taken;
  logic             accept;

  assign r_idx = req_pc[2 +: IDX_W];
  assign r_tag = req_pc[2+IDX_W +: TAG_W];

  always_comb begin
    l_v   = v_q[r_idx];
    l_tag = tag_q[r_idx];
    l_tgt = tgt_q[r_idx];
    l_ctr = ctr_q[r_idx];
`ifdef BP_UPDATE_BYPASS_EN
    if (u_wr && (u_idx == r_idx)) begin
      l_v   = 1'b1;
      l_tag = u_tag;
      l_tgt = u_tgt;
      l_ctr = u_ctr;
    end
`endif
  end

  assign l_taken     = l_v && (l_tag == r_tag) && l_ctr[1];
  assign req_allowin = !resp_valid || resp_allowin;
  assign accept      = req_valid && req_allowin && !flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resp_valid  <= 1'b0;
      resp_pc     <= '0;
      pred_taken  <= 1'b0;
      pred_target <= '0;
    end else if (flush) begin
      resp_valid <= 1'b0;
    end else if (accept) begin
      resp_valid  <= 1'b1;
      resp_pc     <= req_pc;
      pred_taken  <= l_taken;
      pred_target <= l_taken ? l_tgt : req_pc + 32'd4;
    end else if (resp_allowin) begin
      resp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed vector bench for branch_predictor: table-driven lookups/updates plus stall, flush, bypass and reset sequences.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        req_valid;
  logic [31:0] req_pc;
  logic        req_allowin;
  logic        resp_valid;
  logic        resp_allowin;
  logic [31:0] resp_pc;
  logic        pred_taken;
  logic [31:0] pred_target;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  branch_predictor dut (
    .clk(clk), .rst(rst), .flush(flush),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .req_valid(req_valid), .req_pc(req_pc), .req_allowin(req_allowin),
    .resp_valid(resp_valid), .resp_allowin(resp_allowin), .resp_pc(resp_pc),
    .pred_taken(pred_taken), .pred_target(pred_target)
  );

  typedef struct {
    logic        uv;
    logic [31:0] upc;
    logic        ut;
    logic [31:0] utgt;
    logic        rv;
    logic [31:0] rpc;
    logic        exp_rv;
    logic        exp_tk;
    logic [31:0] exp_tgt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic uv, logic [31:0] upc, logic ut, logic [31:0] utgt,
                              logic rv, logic [31:0] rpc,
                              logic exp_rv, logic exp_tk, logic [31:0] exp_tgt);
    vec_t t;
    t.uv = uv; t.upc = upc; t.ut = ut; t.utgt = utgt;
    t.rv = rv; t.rpc = rpc;
    t.exp_rv = exp_rv; t.exp_tk = exp_tk; t.exp_tgt = exp_tgt;
    return t;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(logic uv, logic [31:0] upc, logic ut, logic [31:0] utgt,
                       logic rv, logic [31:0] rpc, logic ra, logic fl);
    @(negedge clk);
    upd_valid = uv; upd_pc = upc; upd_taken = ut; upd_target = utgt;
    req_valid = rv; req_pc = rpc; resp_allowin = ra; flush = fl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_resp(string name, logic rv, logic [31:0] pc, logic tk, logic [31:0] tgt);
    chk({name, "_rv"}, 32'(resp_valid), 32'(rv));
    if (rv) begin
      chk({name, "_pc"}, resp_pc, pc);
      chk({name, "_tk"}, 32'(pred_taken), 32'(tk));
      chk({name, "_tgt"}, pred_target, tgt);
    end
  endtask

  localparam logic [31:0] PA = 32'h1C00_0010;
  localparam logic [31:0] PB = 32'h1C00_0110;
  localparam logic [31:0] TA = 32'h1C00_0100;
  localparam logic [31:0] TB = 32'h1C00_0200;

  initial begin
    rst = 1'b0; flush = 1'b0; upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0;
    upd_target = '0; req_valid = 1'b0; req_pc = '0; resp_allowin = 1'b1;

    // Counter walk: 2 ->1 ->2,3,3,3 ->2 ->1 ->0,0(sat) then alias replacement.
    vecs.push_back(mk(0, 0, 0, 0,   1, 32'h1C00_0000, 1, 0, 32'h1C00_0004));
    vecs.push_back(mk(1, PA, 1, TA, 0, 0,             0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,   1, PA,            1, 1, TA));
    vecs.push_back(mk(1, PA, 0, 0,  0, 0,             0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,   1, PA,            1, 0, PA + 4));
    for (int k = 0; k < 4; k++) vecs.push_back(mk(1, PA, 1, TA, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, PA, 0, 0,  0, 0,             0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,   1, PA,            1, 1, TA));
    vecs.push_back(mk(1, PA, 0, 0,  0, 0,             0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,   1, PA,            1, 0, PA + 4));
    vecs.push_back(mk(1, PA, 0, 0,  0, 0,             0, 0, 0));
    vecs.push_back(mk(1, PA, 0, 0,  0, 0,             0, 0, 0));
    vecs.push_back(mk(1, PA, 1, TA, 0, 0,             0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,   1, PA,            1, 0, PA + 4));
    vecs.push_back(mk(1, PB, 1, TB, 0, 0,             0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,   1, PA,            1, 0, PA + 4));
    vecs.push_back(mk(0, 0, 0, 0,   1, PB,            1, 1, TB));
    vecs.push_back(mk(1, PA, 0, 0,  0, 0,             0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,   1, PB,            1, 1, TB));
    vecs.push_back(mk(0, 0, 0, 0,   1, 32'hFFFF_FFFC, 1, 0, 32'h0000_0000));
    vecs.push_back(mk(0, 0, 0, 0,   1, 32'h0000_0040, 1, 0, 32'h0000_0044));

    repeat (2) @(posedge clk);
    #1;
    chk("reset_rv",  32'(resp_valid), 0);
    chk("reset_pc",  resp_pc, 0);
    chk("reset_tk",  32'(pred_taken), 0);
    chk("reset_tgt", pred_target, 0);
    chk("reset_allowin", 32'(req_allowin), 1);
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].uv, vecs[i].upc, vecs[i].ut, vecs[i].utgt, vecs[i].rv, vecs[i].rpc, 1'b1, 1'b0);
      step();
      chk_resp($sformatf("vec%0d", i), vecs[i].exp_rv, vecs[i].rpc, vecs[i].exp_tk, vecs[i].exp_tgt);
    end

    // Stall: response for PB held while the entry is weakened underneath it.
    drive(0, 0, 0, 0, 1, PB, 1, 0);
    step();
    chk_resp("stall_pre", 1, PB, 1, TB);
    for (int k = 0; k < 3; k++) begin
      drive(k < 2, PB, 0, 0, 1, 32'h1C00_0000, 0, 0);
      #1;
      chk($sformatf("stall%0d_allowin", k), 32'(req_allowin), 0);
      step();
      chk_resp($sformatf("stall%0d", k), 1, PB, 1, TB);
    end
    drive(0, 0, 0, 0, 1, 32'h1C00_0000, 1, 0);
    #1;
    chk("release_allowin", 32'(req_allowin), 1);
    step();
    chk_resp("release", 1, 32'h1C00_0000, 0, 32'h1C00_0004);
    drive(0, 0, 0, 0, 1, PB, 1, 0);
    step();
    chk_resp("weakened", 1, PB, 0, PB + 4);

    // Flush kills the pending response and the concurrent request, not the update.
    drive(1, 32'h1C00_0020, 1, 32'h1C00_0300, 1, PA, 1, 1);
    step();
    chk_resp("flush", 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    step();
    chk_resp("post_flush", 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 32'h1C00_0020, 1, 0);
    step();
    chk_resp("flush_upd", 1, 32'h1C00_0020, 1, 32'h1C00_0300);

    // Same-edge update and lookup of a fresh entry.
    drive(1, 32'h1C00_0030, 1, 32'h1C00_0400, 1, 32'h1C00_0030, 1, 0);
    step();
`ifdef BP_UPDATE_BYPASS_EN
    chk_resp("same_edge", 1, 32'h1C00_0030, 1, 32'h1C00_0400);
`else
    chk_resp("same_edge", 1, 32'h1C00_0030, 0, 32'h1C00_0034);
`endif
    drive(0, 0, 0, 0, 1, 32'h1C00_0030, 1, 0);
    step();
    chk_resp("same_edge_next", 1, 32'h1C00_0030, 1, 32'h1C00_0400);

    // Asynchronous reset mid-stream empties the table and the response stage.
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("arst_rv",  32'(resp_valid), 0);
    chk("arst_tgt", pred_target, 0);
    @(negedge clk);
    rst = 1'b1;
    drive(0, 0, 0, 0, 1, 32'h1C00_0020, 1, 0);
    step();
    chk_resp("after_arst", 1, 32'h1C00_0020, 0, 32'h1C00_0024);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Direct-mapped BTB with 2-bit saturating direction counters; sits directly downstream of branch_unit and consumes its resolved-branch update stream (valid, inst_pc, branch_taken, branch_target).
- Serves fetch with a registered, one-cycle-latency prediction through a valid/allowin handshake.
- The response stage is flushed by flush_pipeline.flush.

Parameters:
- ENTRIES, 64, number of BTB entries; power of 2, at least 2. IDX_W = log2(ENTRIES).
- TAG_W, 30-IDX_W, tag width. Tag = pc[2+IDX_W +: TAG_W], truncated if narrower than the remaining bits.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  pipeline flush (flush_pipeline.flush).
- upd_valid  in  1  resolved branch from branch_unit (predictor.valid).
- upd_pc  in  32  branch instruction PC.
- upd_taken  in  1  resolved direction.
- upd_target  in  32  resolved target.
- req_valid  in  1  fetch lookup request.
- req_pc  in  32  fetch PC, word aligned.
- req_allowin  out  1  predictor can accept a request this cycle.
- resp_valid  out  1  prediction valid.
- resp_allowin  in  1  fetch consumes the prediction.
- resp_pc  out  32  PC of the prediction.
- pred_taken  out  1  predicted taken.
- pred_target  out  32  predicted next PC.

Behaviour:
- Index and tag: idx = pc[2+IDX_W-1:2]. Each entry holds v, tag[TAG_W], target[32], ctr[2].
- Reset (rst=0, asynchronous):
  - All entry v bits cleared.
  - resp_valid=0; resp_pc, pred_taken and pred_target reset to 0.
  - Target and ctr storage is not reset.
  - Deasserting rst mid-stream leaves an empty table and no pending response.
- Handshake:
  - req_allowin = !resp_valid | resp_allowin.
  - A request is accepted when req_valid & req_allowin & !flush.
  - An accepted request at edge N gives resp_valid=1 after N, with outputs computed from the table state read at N. Latency is 1 cycle.
  - Back-to-back accepts give one response per cycle.
  - Stall: while resp_valid & !resp_allowin, all response outputs hold their captured values. The table is not re-read.
  - Response dropped, no new one: resp_valid goes 0 at the edge if it was consumed (resp_allowin=1) and no new request was accepted.
- Prediction:
  - hit = v & (tag == req tag).
  - If hit & ctr[1]: pred_taken=1, pred_target=entry.target.
  - Otherwise: pred_taken=0, pred_target=req_pc+4, mod 2^32 (0xFFFFFFFC gives 0x00000000).
- Update (upd_valid at an edge; independent of flush and of the handshake):
  - Hit, taken: ctr = min(ctr+1, 3); target = upd_target.
  - Hit, not taken: ctr = max(ctr-1, 0); target unchanged; v stays 1.
  - Miss, taken: allocate or overwrite the entry with v=1, new tag, target = upd_target, ctr=2 (weak taken). This replaces any aliasing occupant.
  - Miss, not taken: no change.
- Flush:
  - Clears resp_valid at the edge.
  - A request presented in the flush cycle is not accepted.
  - Updates in the flush cycle are still applied; resolved branches are architecturally correct.
- Update and request same index, same edge: see the optional feature. Default: the lookup sees the pre-update entry.

Optional Feature:
- Macro: BP_UPDATE_BYPASS_EN.
- Defined: an accepted request and upd_valid at the same edge with matching idx make the lookup use the post-update entry (counter, tag, v, target) as computed by the update rules.
- Undefined: the lookup uses the pre-update entry, and the update lands one cycle later.

Test Plan:
- Reset then lookup 0x1C000000 -> resp_valid=1 next cycle, pred_taken=0, pred_target=0x1C000004.
- Update pc=0x1C000010 taken to 0x1C000100, then lookup 0x1C000010 -> pred_taken=1, target=0x1C000100 (ctr=2). One not-taken update -> ctr=1, pred_taken=0. Four taken updates -> ctr saturates at 3; one not-taken -> still taken.
- Alias: ENTRIES=64, entry at 0x1C000010 taken; taken update at 0x1C000110 (same idx) -> lookup 0x1C000010 misses (target pc+4); lookup 0x1C000110 hits.
- Stall: resp_allowin=0 for 3 cycles with req_valid=1 -> req_allowin=0, outputs frozen; resp_allowin=1 -> next request accepted, new response the following cycle.
- Flush with resp_valid=1 and req_valid=1 -> resp_valid=0 next cycle, no response for that request; a simultaneous update is still visible on a later lookup.
- Same-edge update (taken, new entry) and lookup of the same pc -> pred_taken=0 without BP_UPDATE_BYPASS_EN; pred_taken=1, target=upd_target with it.
